// File: rtl/pow2n_pipe.sv
// pow2n_pipe: streaming x^(2^STAGES) mod 2^OUT_W via STAGES registered squaring stages.
// Latency: STAGES cycles accept-to-m_valid when unstalled; 1 item/cycle throughput.
// Backpressure: per-stage ready chain; empty stages keep accepting, so up to STAGES items are held.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  operand stream in, s_tag sideband travels with the item
//   m_valid/m_ready/m_data  result stream out, m_tag is the tag of the result item
//   busy                    any stage holds an item
//   m_ovf                   result was truncated (only when POW_OVF_EN is defined)
// Optional feature macro: POW_OVF_EN (per-item sticky overflow flag and m_ovf port).
module pow2n_pipe #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             busy
`ifdef POW_OVF_EN
  ,
  output logic             m_ovf
`endif
);

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            rdy;
  logic [STAGES-1:0][OUT_W-1:0] d_q, d_d;
  logic [STAGES-1:0][TAG_W-1:0] t_q, t_d;

`ifdef POW_OVF_EN
  typedef logic [2*OUT_W-1:0] wide_t;
  logic [STAGES-1:0] o_q, o_d;
  wide_t             prod_w;
`endif

  // Ready ripples back from the output; a stage can take a new item when it
  // is empty or when its own item is moving on this edge.
  always_comb begin : ready_chain
    rdy = '0;
    rdy[STAGES-1] = ~v_q[STAGES-1] | m_ready;
    for (int k = STAGES-2; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  always_comb begin : next_state
    v_d = v_q;
    d_d = d_q;
    t_d = t_q;
`ifdef POW_OVF_EN
    o_d    = o_q;
    prod_w = '0;
`endif

    // Stage 0: the operand is zero-extended before squaring, and the
    // result width is at least twice the operand width, so this is exact.
    if (rdy[0]) begin
      v_d[0] = s_valid;
      if (s_valid) begin
        d_d[0] = OUT_W'(s_data) * OUT_W'(s_data);
        t_d[0] = s_tag;
`ifdef POW_OVF_EN
        o_d[0] = 1'b0;
`endif
      end
    end

    for (int k = 1; k < STAGES; k++) begin
`ifdef POW_OVF_EN
      // Full-width product so the discarded upper half can be inspected.
      prod_w = wide_t'(d_q[k-1]) * wide_t'(d_q[k-1]);
`endif
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
`ifdef POW_OVF_EN
          d_d[k] = prod_w[OUT_W-1:0];
          o_d[k] = o_q[k-1] | (|prod_w[2*OUT_W-1:OUT_W]);
`else
          // Same-width operands: the product is naturally the low half.
          d_d[k] = d_q[k-1] * d_q[k-1];
`endif
          t_d[k] = t_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      d_q <= '0;
      t_q <= '0;
`ifdef POW_OVF_EN
      o_q <= '0;
`endif
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      t_q <= t_d;
`ifdef POW_OVF_EN
      o_q <= o_d;
`endif
    end
  end

  assign s_ready = rdy[0];
  assign m_valid = v_q[STAGES-1];
  assign m_data  = d_q[STAGES-1];
  assign m_tag   = t_q[STAGES-1];
  assign busy    = |v_q;
`ifdef POW_OVF_EN
  assign m_ovf   = o_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pow2n_pipe.sv
// tb_pow2n_pipe: directed and random-backpressure bench for pow2n_pipe (default parameters).
// A queue-based reference computes x^8 by repeated multiplication and is checked every output cycle.
// Directed sections pin latency, ordering, bubble collapse, stall stability and async reset.
module tb_pow2n_pipe;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 64;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int EXPN   = 1 << STAGES;

  logic             clk;
  logic             rstn;
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             busy;
`ifdef POW_OVF_EN
  logic             m_ovf;
`endif

  pow2n_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .busy(busy)
`ifdef POW_OVF_EN
    , .m_ovf(m_ovf)
`endif
  );

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  t;
    logic        o;
  } item_t;

  item_t       exp_q[$];
  item_t       out_log[$];
  int          out_cyc[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_d;
  logic [3:0]  prev_t;
  item_t       obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // x^EXPN by plain repeated multiplication; overflow means the exact power
  // does not fit in 64 bits.
  function automatic item_t model(input logic [31:0] x, input logic [3:0] tg);
    logic [127:0] r;
    item_t        it;
    it = '0;
    r  = 128'd1;
    for (int i = 0; i < EXPN; i++) begin
      r = {64'd0, r[63:0]} * {96'd0, x};
      if (r[127:64] != 64'd0) it.o = 1'b1;
    end
    it.d = r[63:0];
    it.t = tg;
    return it;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [3:0] tg, output int waited);
    logic acc;
    acc     = 1'b0;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = x;
    s_tag   = tg;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: item %0d not accepted, got 0 acceptances, required 1", x);
    end
  endtask

  // Scoreboard: every cycle the output is meaningful it must equal the oldest
  // outstanding accepted item, and a stalled output must not change.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_d);
        chk("hold_tag", m_tag, prev_t);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_m_valid", m_valid, 0);
        end else begin
          chk("m_data", m_data, exp_q[0].d);
          chk("m_tag", m_tag, exp_q[0].t);
`ifdef POW_OVF_EN
          chk("m_ovf", m_ovf, exp_q[0].o);
`endif
        end
      end
      stall_prev = m_valid & ~m_ready;
      prev_d     = m_data;
      prev_t     = m_tag;
      if (m_valid && m_ready) begin
        obs.d = m_data;
        obs.t = m_tag;
`ifdef POW_OVF_EN
        obs.o = m_ovf;
`else
        obs.o = 1'b0;
`endif
        out_log.push_back(obs);
        out_cyc.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) exp_q.push_back(model(s_data, s_tag));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    item_t p;
    int    w;
    int    lat;
    int    base;
    int    acc;
    int    cycles;
    logic  fire;

    // Pin the reference model with hand-computed values.
    p = model(32'd2, 4'd0);
    chk("model_2", p.d, 64'd256);
    p = model(32'd255, 4'd0);
    chk("model_255", p.d, 64'd17878103347812890625);
    chk("model_255_ovf", p.o, 0);
    p = model(32'd256, 4'd0);
    chk("model_256_ovf", p.o, 1);

    // Reset held with a valid input present.
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'd7;
    s_tag   = 4'd5;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 1);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 3);
    chk("first_data", m_data, 64'd5764801);
    chk("first_tag", m_tag, 5);

    // Back-to-back streaming.
    repeat (4) @(posedge clk);
    #1;
    base = out_log.size();
    send(32'd2, 4'd1, w);
    send(32'd3, 4'd2, w);
    send(32'd255, 4'd3, w);
    repeat (6) @(negedge clk);
    chk("stream_count", out_log.size(), base + 3);
    if (out_log.size() >= base + 3) begin
      chk("stream_d0", out_log[base].d, 64'd256);
      chk("stream_t0", out_log[base].t, 1);
      chk("stream_d1", out_log[base+1].d, 64'd6561);
      chk("stream_t1", out_log[base+1].t, 2);
      chk("stream_d2", out_log[base+2].d, 64'd17878103347812890625);
      chk("stream_t2", out_log[base+2].t, 3);
      chk("stream_gap01", out_cyc[base+1] - out_cyc[base], 1);
      chk("stream_gap12", out_cyc[base+2] - out_cyc[base+1], 1);
    end

    // Bubble collapse under a stalled consumer.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    base = out_log.size();
    send(32'd1, 4'd4, w);
    chk("bubble_wait1", w, 0);
    repeat (2) @(posedge clk);
    #1;
    send(32'd2, 4'd5, w);
    chk("bubble_wait2", w, 0);
    send(32'd3, 4'd6, w);
    chk("bubble_wait3", w, 0);
    @(negedge clk);
    chk("full_s_ready", s_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_head", m_data, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 32'd4;
    s_tag   = 4'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall4_s_ready", s_ready, 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("pop_push_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("one_pop", out_log.size(), base + 1);
    chk("refull_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("bubble_count", out_log.size(), base + 4);
    if (out_log.size() >= base + 4) begin
      chk("bubble_d0", out_log[base].d, 64'd1);
      chk("bubble_d1", out_log[base+1].d, 64'd256);
      chk("bubble_d2", out_log[base+2].d, 64'd6561);
      chk("bubble_d3", out_log[base+3].d, 64'd65536);
      chk("bubble_t3", out_log[base+3].t, 7);
    end

`ifdef POW_OVF_EN
    // Overflow flag travels with its item.
    @(posedge clk);
    #1;
    base = out_log.size();
    send(32'd256, 4'd1, w);
    send(32'd255, 4'd2, w);
    repeat (6) @(negedge clk);
    chk("ovf_count", out_log.size(), base + 2);
    if (out_log.size() >= base + 2) begin
      chk("ovf256_data", out_log[base].d, 64'd0);
      chk("ovf256_flag", out_log[base].o, 1);
      chk("ovf255_flag", out_log[base+1].o, 0);
    end
`endif

    // Random traffic with random backpressure.
    @(posedge clk);
    #1;
    acc    = 0;
    cycles = 0;
    while (acc < 1000 && cycles < 20000) begin
      if (!s_valid && $urandom_range(3) != 0) begin
        s_valid = 1'b1;
        s_data  = ($urandom_range(3) == 0) ? 32'($urandom_range(300)) : $urandom;
        s_tag   = 4'($urandom_range(15));
      end
      m_ready = ($urandom_range(1) == 1);
      @(negedge clk);
      fire = s_valid & s_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (fire) begin
        acc++;
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk("random_accepted", acc, 1000);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_outstanding", exp_q.size(), 0);

    // Asynchronous reset with three items stuck in the pipe.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send(32'd10, 4'd1, w);
    send(32'd11, 4'd2, w);
    send(32'd12, 4'd3, w);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_s_ready", s_ready, 1);
    chk("async_m_data", m_data, 0);
    chk("async_m_tag", m_tag, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn    = 1'b1;
    m_ready = 1'b1;
    base    = out_log.size();
    repeat (8) @(negedge clk);
    chk("no_stale_out", out_log.size(), base);
    chk("no_stale_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
